// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
package core_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned BR_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd6
    } state_t;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_ADDU = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SLT  = 4'd8
    } alu_ctrl_t;

    typedef enum logic [BR_W-1:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_GT  = 3'd2,
        BR_GTE = 3'd3,
        BR_LT  = 3'd4,
        BR_LTE = 3'd5
    } br_cond_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [3:0] {
        CLS_RALU    = 4'd0,
        CLS_IALU    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_J       = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JR      = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_t;

    // Decoder result bundle handed from ctrl_opdecode to the FSM.
    typedef struct packed {
        instr_class_t cls;
        alu_ctrl_t    alu;
        br_cond_t     br;
        logic         illegal;
    } decode_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGT   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_BLEQ  = 6'd21;
    localparam logic [5:0] OP_BGTE  = 6'd24;
    localparam logic [5:0] OP_BLE   = 6'd25;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode/func decoder: instruction class, ALU op, branch condition.
module ctrl_opdecode
    import core_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    instr_class_t cls;
    alu_ctrl_t    alu;
    br_cond_t     br;

    // Classify the instruction; anything not listed is illegal.
    always_comb begin
        cls = CLS_ILLEGAL;
        alu = ALU_ADD;
        br  = BR_EQ;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_RALU;
                case (funct)
                    FN_ADD:  alu = ALU_ADD;
                    FN_ADDU: alu = ALU_ADDU;
                    FN_SUB:  alu = ALU_SUB;
                    FN_SUBU: alu = ALU_SUBU;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_SLL:  alu = ALU_SLL;
                    FN_SRL:  alu = ALU_SRL;
                    FN_SLT:  alu = ALU_SLT;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            OP_ADDI:  begin cls = CLS_IALU; alu = ALU_ADD;  end
            OP_ADDIU: begin cls = CLS_IALU; alu = ALU_ADDU; end
            OP_ANDI:  begin cls = CLS_IALU; alu = ALU_AND;  end
            OP_ORI:   begin cls = CLS_IALU; alu = ALU_OR;   end
            OP_SLTI:  begin cls = CLS_IALU; alu = ALU_SLT;  end
            OP_LW:    begin cls = CLS_LOAD;  alu = ALU_ADD; end
            OP_SW:    begin cls = CLS_STORE; alu = ALU_ADD; end
            OP_BEQ:   begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_EQ;  end
            OP_BNE:   begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_NE;  end
            OP_BGT:   begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_GT;  end
            OP_BGTE:  begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_GTE; end
            OP_BLE:   begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_LT;  end
            OP_BLEQ:  begin cls = CLS_BRANCH; alu = ALU_SUB; br = BR_LTE; end
            default:  cls = CLS_ILLEGAL;
        endcase
    end

    // Pack the decode result.
    always_comb begin
        dec.cls     = cls;
        dec.alu     = alu;
        dec.br      = br;
        dec.illegal = (cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset core: sequences each instruction
// and drives all datapath strobes; memory waits are bounded by MEM_TIMEOUT.
module multicycle_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        cond_true,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_b,
    output logic [2:0]  br_cond,
    output logic [2:0]  state,
    output logic        busy,
    output logic        retired,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q;
    state_t           state_d;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_c;
    decode_t          dec;

    // Register-field bits are datapath-only.
    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    ctrl_opdecode u_opdecode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    // Last permitted wait cycle with memory still not ready.
    assign timeout_c = (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

    // Next state and strobes from (state, IR decode, mem_ready, cond_true).
    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        ir_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        reg_write = 1'b0;
        reg_dst   = DST_RT;
        wb_sel    = WB_ALU;
        alu_ctrl  = ALU_ADD;
        alu_src_b = 1'b0;
        br_cond   = BR_EQ;
        retired   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ready) begin
                    mem_req  = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SEQ;
                    state_d  = DECODE;
                end else if (timeout_c) begin
                    state_d = ERR;
                end else begin
                    mem_req = 1'b1;
                end
            end
            DECODE: begin
                if (dec.illegal) begin
                    state_d = ERR;
                end else begin
                    case (dec.cls)
                        CLS_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            retired  = 1'b1;
                        end
                        CLS_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = PC_JUMP;
                            reg_write = 1'b1;
                            reg_dst   = DST_RA;
                            wb_sel    = WB_PC4;
                            retired   = 1'b1;
                        end
                        CLS_JR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_REG;
                            retired  = 1'b1;
                        end
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: begin
                alu_ctrl = dec.alu;
                case (dec.cls)
                    CLS_RALU: begin
                        alu_src_b = 1'b0;
                        state_d   = WB;
                    end
                    CLS_IALU: begin
                        alu_src_b = 1'b1;
                        state_d   = WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_ctrl  = ALU_ADD;
                        alu_src_b = 1'b1;
                        state_d   = MEM;
                    end
                    CLS_BRANCH: begin
                        br_cond  = dec.br;
                        pc_write = cond_true;
                        pc_src   = PC_BRANCH;
                        retired  = 1'b1;
                    end
                    default: state_d = ERR;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (dec.cls == CLS_STORE);
                    if (dec.cls == CLS_STORE) retired = 1'b1;
                    else                      state_d = WB;
                end else if (timeout_c) begin
                    state_d = ERR;
                end else begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (dec.cls == CLS_STORE);
                end
            end
            WB: begin
                reg_write = 1'b1;
                reg_dst   = (dec.cls == CLS_RALU) ? DST_RD : DST_RT;
                wb_sel    = (dec.cls == CLS_LOAD) ? WB_MEM : WB_ALU;
                retired   = 1'b1;
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase

        if (retired) state_d = run ? FETCH : IDLE;
    end

    // State, sticky error and memory-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | (state_d == ERR);
            if (state_d != state_q)
                cnt_q <= '0;
            else if (((state_q == FETCH) || (state_q == MEM)) && !mem_ready)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE) && (state_q != ERR);
    assign err   = err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with hand-computed expectations.
module tb_multicycle_controller;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw   $2,4($1)
    localparam logic [31:0] I_SW   = 32'hAC22_0004; // sw   $2,4($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_0003; // beq  $1,$2,3
    localparam logic [31:0] I_BLEQ = 32'h5422_0003; // bleq $1,$2,3
    localparam logic [31:0] I_JAL  = 32'h0C00_0100; // jal  0x100
    localparam logic [31:0] I_J    = 32'h0800_0100; // j    0x100
    localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr   $31
    localparam logic [31:0] I_ANDI = 32'h3022_000F; // andi $2,$1,15
    localparam logic [31:0] I_ILL  = 32'hFC00_0000; // opcode 111111

    localparam int S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_ERR = 6;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ready, cond_true;
    logic [31:0] instr;
    logic        pc_write, ir_write, mem_req, mem_we, iord, reg_write, alu_src_b;
    logic        busy, retired, err;
    logic [1:0]  pc_src, reg_dst, wb_sel;
    logic [3:0]  alu_ctrl;
    logic [2:0]  br_cond, state;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
        .mem_ready(mem_ready), .cond_true(cond_true),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b), .br_cond(br_cond),
        .state(state), .busy(busy), .retired(retired), .err(err)
    );

    // Strobe vector: {pc_write,pc_src,ir_write,mem_req,mem_we,iord,reg_write,reg_dst,wb_sel,alu_src_b,retired}
    function automatic logic [13:0] sv(input logic pw, input logic [1:0] ps, input logic iw,
                                       input logic mr, input logic we, input logic io,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                                       input logic sb, input logic rt);
        return {pw, ps, iw, mr, we, io, rw, rd, wb, sb, rt};
    endfunction

    logic [13:0] obs;
    assign obs = {pc_write, pc_src, ir_write, mem_req, mem_we, iord,
                  reg_write, reg_dst, wb_sel, alu_src_b, retired};

    logic [13:0] s_none, s_fetch, s_memw;
    initial begin
        s_none  = 14'd0;
        s_fetch = sv(1, 2'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0);
        s_memw  = sv(0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input int st, input logic [13:0] s);
        #1;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".strobes"}, 32'(obs), 32'(s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; instr = 32'd0; mem_ready = 1'b0; cond_true = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        look("rst", S_IDLE, s_none);
        check("rst.alu", 32'(alu_ctrl), 0);
        check("rst.err", 32'(err), 0);
        check("rst.busy", 32'(busy), 0);

        // add, mem_ready same cycle: FETCH,DECODE,EXEC,WB
        run = 1'b1; instr = I_ADD; mem_ready = 1'b1;
        look("add.idle", S_IDLE, s_none); step();
        look("add.fetch", S_FETCH, s_fetch);
        check("add.busy", 32'(busy), 1); step();
        look("add.dec", S_DEC, s_none); step();
        look("add.exec", S_EXEC, s_none);
        check("add.alu", 32'(alu_ctrl), 0); step();
        look("add.wb", S_WB, sv(0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 1)); step();

        // lw with 3 wait cycles in MEM
        instr = I_LW;
        look("lw.fetch", S_FETCH, s_fetch); step();
        look("lw.dec", S_DEC, s_none); step();
        look("lw.exec", S_EXEC, sv(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0));
        check("lw.alu", 32'(alu_ctrl), 0);
        mem_ready = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            look("lw.memwait", S_MEM, s_memw); step();
        end
        mem_ready = 1'b1;
        look("lw.memdone", S_MEM, s_memw); step();
        look("lw.wb", S_WB, sv(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 1)); step();

        // beq not taken, then taken
        instr = I_BEQ; cond_true = 1'b0;
        look("beq0.fetch", S_FETCH, s_fetch); step();
        look("beq0.dec", S_DEC, s_none); step();
        look("beq0.exec", S_EXEC, sv(0, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1));
        check("beq0.br", 32'(br_cond), 0);
        check("beq0.alu", 32'(alu_ctrl), 1); step();
        look("beq1.fetch", S_FETCH, s_fetch); step();
        look("beq1.dec", S_DEC, s_none); step();
        cond_true = 1'b1;
        look("beq1.exec", S_EXEC, sv(1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1)); step();

        // bleq taken: condition select 101
        instr = I_BLEQ;
        look("bleq.fetch", S_FETCH, s_fetch); step();
        look("bleq.dec", S_DEC, s_none); step();
        look("bleq.exec", S_EXEC, sv(1, 2'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1));
        check("bleq.br", 32'(br_cond), 5); step();

        // jal / jr / j retire in DECODE
        instr = I_JAL;
        look("jal.fetch", S_FETCH, s_fetch); step();
        look("jal.dec", S_DEC, sv(1, 2'd2, 0, 0, 0, 0, 1, 2'd2, 2'd2, 0, 1)); step();
        instr = I_JR;
        look("jr.fetch", S_FETCH, s_fetch); step();
        look("jr.dec", S_DEC, sv(1, 2'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1)); step();
        instr = I_J;
        look("j.fetch", S_FETCH, s_fetch); step();
        look("j.dec", S_DEC, sv(1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1)); step();

        // andi: immediate ALU op, rt destination
        instr = I_ANDI;
        look("andi.fetch", S_FETCH, s_fetch); step();
        look("andi.dec", S_DEC, s_none); step();
        look("andi.exec", S_EXEC, sv(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0));
        check("andi.alu", 32'(alu_ctrl), 4); step();
        look("andi.wb", S_WB, sv(0, 2'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 1)); step();

        // sw retires in MEM
        instr = I_SW;
        look("sw.fetch", S_FETCH, s_fetch); step();
        look("sw.dec", S_DEC, s_none); step();
        look("sw.exec", S_EXEC, sv(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0)); step();
        look("sw.mem", S_MEM, sv(0, 2'd0, 0, 1, 1, 1, 0, 2'd0, 2'd0, 0, 1)); step();

        // run dropped during EXEC: instruction completes, then IDLE
        instr = I_ADD;
        look("stop.fetch", S_FETCH, s_fetch); step();
        look("stop.dec", S_DEC, s_none); step();
        run = 1'b0;
        look("stop.exec", S_EXEC, s_none); step();
        look("stop.wb", S_WB, sv(0, 2'd0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 1)); step();
        look("stop.idle", S_IDLE, s_none); step();
        look("stop.idle2", S_IDLE, s_none);

        // reset asserted while waiting in MEM
        run = 1'b1; instr = I_LW; step();
        look("rmem.fetch", S_FETCH, s_fetch); step();
        look("rmem.dec", S_DEC, s_none); step();
        look("rmem.exec", S_EXEC, sv(0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0));
        mem_ready = 1'b0; step();
        look("rmem.mem", S_MEM, s_memw);
        rst_n = 1'b0;
        look("rmem.rst", S_IDLE, s_none);
        run = 1'b0;
        rst_n = 1'b1;
        step();
        look("rmem.idle", S_IDLE, s_none);

        // fetch timeout: 15 cycles without mem_ready -> ERR
        run = 1'b1; step();
        for (int k = 1; k < 15; k++) begin
            look("to.wait", S_FETCH, sv(0, 2'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0)); step();
        end
        look("to.last", S_FETCH, s_none); step();
        look("to.err", S_ERR, s_none);
        check("to.errflag", 32'(err), 1);
        check("to.busy", 32'(busy), 0);

        // illegal opcode after reset
        rst_n = 1'b0;
        #2;
        check("ill.rst_err", 32'(err), 0);
        check("ill.rst_state", 32'(state), S_IDLE);
        rst_n = 1'b1; instr = I_ILL; mem_ready = 1'b1; run = 1'b1;
        step();
        look("ill.fetch", S_FETCH, s_fetch); step();
        look("ill.dec", S_DEC, s_none); step();
        look("ill.err", S_ERR, s_none);
        check("ill.errflag", 32'(err), 1);
        repeat (3) step();
        look("ill.sticky", S_ERR, s_none);
        check("ill.sticky_err", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1);
    end

endmodule
